// File: rtl/parking_access_ctrl.sv
// PIN-controlled parking gate: Moore FSM with wrong-PIN and tailgating alarms.
// Optional open-gate timeout is compiled in by defining PARKING_TIMEOUT_EN.
module parking_access_ctrl #(
  parameter int                PIN_W          = 16,
  parameter logic [PIN_W-1:0]  CLAVE_CORRECTA = 16'h1234,
  parameter int                MAX_INTENTOS   = 3,
  parameter int                TIMEOUT_CICLOS = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sensor_llegada_vehiculo,
  input  logic             sensor_ingreso_vehiculo,
  input  logic [PIN_W-1:0] clave_ingresada,
  input  logic             clave_valida,
  output logic             senal_compuerta,
  output logic             senal_alarma_pin,
  output logic             senal_alarma_bloqueo,
  output logic [1:0]       estado
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ESPERA_CLAVE = 2'd1,
    ABIERTA      = 2'd2,
    BLOQUEO      = 2'd3
  } state_t;

  localparam int              CNT_W   = $clog2(MAX_INTENTOS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INTENTOS);

  if (MAX_INTENTOS < 1 || TIMEOUT_CICLOS < 1) begin : g_param_check
    $error("parking_access_ctrl: MAX_INTENTOS and TIMEOUT_CICLOS must be >= 1");
  end

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   intentos_reg, intentos_next;
  logic               alarma_pin_reg, alarma_pin_next;
  logic               compuerta_reg, compuerta_next;
  logic               bloqueo_reg, bloqueo_next;
  logic               clave_ok;
  logic               tmo_expired;

  assign clave_ok = (clave_ingresada == CLAVE_CORRECTA);

`ifdef PARKING_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CICLOS - 1);

  logic [TMO_W-1:0] tmo_reg;

  // Held at zero outside ABIERTA, so it starts from zero on every entry.
  always_ff @(posedge clock) begin
    if (reset || state_reg != ABIERTA) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_reg + 1'b1;
    end
  end

  assign tmo_expired = (state_reg == ABIERTA) && (tmo_reg == TMO_LAST);
`else
  assign tmo_expired = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      intentos_reg   <= '0;
      alarma_pin_reg <= 1'b0;
      compuerta_reg  <= 1'b0;
      bloqueo_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      intentos_reg   <= intentos_next;
      alarma_pin_reg <= alarma_pin_next;
      compuerta_reg  <= compuerta_next;
      bloqueo_reg    <= bloqueo_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    intentos_next   = intentos_reg;
    alarma_pin_next = alarma_pin_reg;
    case (state_reg)
      IDLE: begin
        if (sensor_llegada_vehiculo) state_next = ESPERA_CLAVE;
      end
      ESPERA_CLAVE: begin
        // A PIN strobe wins over the vehicle leaving in the same cycle.
        if (clave_valida) begin
          if (clave_ok) begin
            state_next      = ABIERTA;
            intentos_next   = '0;
            alarma_pin_next = 1'b0;
          end else begin
            if (intentos_reg != MAX_CNT) intentos_next = intentos_reg + 1'b1;
            if (intentos_next == MAX_CNT) alarma_pin_next = 1'b1;
          end
        end else if (!sensor_llegada_vehiculo) begin
          state_next    = IDLE;
          intentos_next = '0;
        end
      end
      ABIERTA: begin
        if (sensor_ingreso_vehiculo) begin
          state_next = sensor_llegada_vehiculo ? BLOQUEO : IDLE;
        end else if (tmo_expired) begin
          state_next = IDLE;
        end
      end
      BLOQUEO: begin
        if (clave_valida && clave_ok) begin
          state_next      = IDLE;
          intentos_next   = '0;
          alarma_pin_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered alongside it
  always_comb begin
    compuerta_next = (state_next == ABIERTA);
    bloqueo_next   = (state_next == BLOQUEO);
  end

  assign senal_compuerta      = compuerta_reg;
  assign senal_alarma_pin     = alarma_pin_reg;
  assign senal_alarma_bloqueo = bloqueo_reg;
  assign estado               = state_reg;

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Bench for parking_access_ctrl: directed vector table, timeout sequences,
// and randomized traffic checked against a rule-level reference model.
module tb_parking_access_ctrl;

  localparam int          PIN_W = 16;
  localparam logic [15:0] KEY   = 16'h1234;
  localparam logic [15:0] ZERO  = 16'h0000;
  localparam int          MAXI  = 3;
  localparam int          TMO   = 8;
`ifdef PARKING_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             llegada = 1'b0;
  logic             ingreso = 1'b0;
  logic             valida = 1'b0;
  logic [PIN_W-1:0] clave = '0;
  logic             compuerta, alarma_pin, alarma_bloqueo;
  logic [1:0]       estado;

  int vectors = 0;
  int miscompares = 0;

  parking_access_ctrl #(
    .PIN_W(PIN_W), .CLAVE_CORRECTA(KEY), .MAX_INTENTOS(MAXI), .TIMEOUT_CICLOS(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sensor_llegada_vehiculo(llegada),
    .sensor_ingreso_vehiculo(ingreso),
    .clave_ingresada(clave),
    .clave_valida(valida),
    .senal_compuerta(compuerta),
    .senal_alarma_pin(alarma_pin),
    .senal_alarma_bloqueo(alarma_bloqueo),
    .estado(estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst, arr, ing, val;
    logic [15:0] pin;
    logic        gate, apin, ablk;
    logic [1:0]  est;
  } vec_t;

  function automatic vec_t mk(input logic r, a, i, v, input logic [15:0] p,
                              input logic g, ap, ab, input logic [1:0] e);
    vec_t t;
    t.rst = r; t.arr = a; t.ing = i; t.val = v; t.pin = p;
    t.gate = g; t.apin = ap; t.ablk = ab; t.est = e;
    return t;
  endfunction

  // Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
  task automatic drive(input logic r, a, i, v, input logic [15:0] p);
    @(negedge clock);
    reset = r; llegada = a; ingreso = i; valida = v; clave = p;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic g, ap, ab, input logic [1:0] e);
    vectors++;
    if (compuerta !== g || alarma_pin !== ap || alarma_bloqueo !== ab || estado !== e) begin
      miscompares++;
      $display("FAIL %s: got gate=%0b pin=%0b blk=%0b estado=%0d, expected gate=%0b pin=%0b blk=%0b estado=%0d",
               name, compuerta, alarma_pin, alarma_bloqueo, estado, g, ap, ab, e);
    end else begin
      $display("vec %0d %s ok: gate=%0b pin=%0b blk=%0b estado=%0d",
               vectors, name, compuerta, alarma_pin, alarma_bloqueo, estado);
    end
  endtask

  // Reference model: the gate situation as booleans plus plain integer counters.
  bit m_waiting, m_open, m_blocked, m_alarm;
  int m_attempts, m_open_cycles;

  task automatic model_step(input logic r, a, i, v, input logic [15:0] p);
    if (r) begin
      m_waiting = 0; m_open = 0; m_blocked = 0; m_alarm = 0;
      m_attempts = 0; m_open_cycles = 0;
    end else if (m_blocked) begin
      if (v && p == KEY) begin
        m_blocked = 0; m_alarm = 0; m_attempts = 0;
      end
    end else if (m_open) begin
      m_open_cycles = m_open_cycles + 1;
      if (i) begin
        m_open = 0;
        m_blocked = a;
      end else if (TMO_EN && m_open_cycles >= TMO) begin
        m_open = 0;
      end
    end else if (m_waiting) begin
      if (v) begin
        if (p == KEY) begin
          m_waiting = 0; m_open = 1; m_open_cycles = 0;
          m_attempts = 0; m_alarm = 0;
        end else begin
          m_attempts = (m_attempts + 1 > MAXI) ? MAXI : m_attempts + 1;
          if (m_attempts == MAXI) m_alarm = 1;
        end
      end else if (!a) begin
        m_waiting = 0; m_attempts = 0;
      end
    end else if (a) begin
      m_waiting = 1;
    end
  endtask

  function automatic logic [1:0] model_estado();
    if (m_blocked) return 2'd3;
    if (m_open) return 2'd2;
    if (m_waiting) return 2'd1;
    return 2'd0;
  endfunction

  vec_t tbl [41];

  initial begin
    tbl[0]  = mk(1,0,0,0,ZERO, 0,0,0,0);
    tbl[1]  = mk(0,1,0,0,ZERO, 0,0,0,1);
    tbl[2]  = mk(0,1,0,1,KEY,  1,0,0,2);
    tbl[3]  = mk(0,0,1,0,ZERO, 0,0,0,0);
    tbl[4]  = mk(0,1,0,0,ZERO, 0,0,0,1);
    tbl[5]  = mk(0,1,0,1,ZERO, 0,0,0,1);
    tbl[6]  = mk(0,1,0,1,ZERO, 0,0,0,1);
    tbl[7]  = mk(0,1,0,1,ZERO, 0,1,0,1);
    tbl[8]  = mk(0,1,0,1,ZERO, 0,1,0,1);
    tbl[9]  = mk(0,1,0,1,KEY,  1,0,0,2);
    tbl[10] = mk(0,1,1,0,ZERO, 0,0,1,3);
    tbl[11] = mk(0,1,0,1,ZERO, 0,0,1,3);
    tbl[12] = mk(0,0,1,0,ZERO, 0,0,1,3);
    tbl[13] = mk(0,0,0,1,KEY,  0,0,0,0);
    tbl[14] = mk(0,1,0,0,ZERO, 0,0,0,1);
    tbl[15] = mk(0,1,0,1,KEY,  1,0,0,2);
    tbl[16] = mk(0,1,1,0,ZERO, 0,0,1,3);
    tbl[17] = mk(1,1,1,1,KEY,  0,0,0,0);
    tbl[18] = mk(0,1,0,0,ZERO, 0,0,0,1);
    tbl[19] = mk(0,0,0,1,ZERO, 0,0,0,1);
    tbl[20] = mk(0,0,0,0,ZERO, 0,0,0,0);
    tbl[21] = mk(0,1,0,0,ZERO, 0,0,0,1);
    tbl[22] = mk(0,1,0,1,ZERO, 0,0,0,1);
    tbl[23] = mk(0,1,0,1,ZERO, 0,0,0,1);
    tbl[24] = mk(0,1,0,1,ZERO, 0,1,0,1);
    tbl[25] = mk(0,0,0,0,ZERO, 0,1,0,0);
    tbl[26] = mk(0,1,0,0,ZERO, 0,1,0,1);
    tbl[27] = mk(0,1,0,1,ZERO, 0,1,0,1);
    tbl[28] = mk(0,1,0,1,KEY,  1,0,0,2);
    tbl[29] = mk(0,1,0,1,KEY,  1,0,0,2);
    tbl[30] = mk(0,0,1,0,ZERO, 0,0,0,0);
    tbl[31] = mk(0,0,0,1,KEY,  0,0,0,0);
    tbl[32] = mk(0,1,0,0,ZERO, 0,0,0,1);
    tbl[33] = mk(0,1,0,1,ZERO, 0,0,0,1);
    tbl[34] = mk(0,1,0,1,ZERO, 0,0,0,1);
    tbl[35] = mk(0,0,0,0,ZERO, 0,0,0,0);
    tbl[36] = mk(0,1,0,0,ZERO, 0,0,0,1);
    tbl[37] = mk(0,1,0,1,ZERO, 0,0,0,1);
    tbl[38] = mk(0,1,0,1,ZERO, 0,0,0,1);
    tbl[39] = mk(0,1,0,1,ZERO, 0,1,0,1);
    tbl[40] = mk(1,0,0,0,ZERO, 0,0,0,0);

    for (int k = 0; k < 41; k++) begin
      drive(tbl[k].rst, tbl[k].arr, tbl[k].ing, tbl[k].val, tbl[k].pin);
      check($sformatf("table[%0d]", k), tbl[k].gate, tbl[k].apin, tbl[k].ablk, tbl[k].est);
    end

    // Open gate left unused: closes after TMO cycles only when the timeout is built in.
    drive(1,0,0,0,ZERO);
    drive(0,1,0,0,ZERO);
    drive(0,1,0,1,KEY);
    check("open_for_timeout", 1,0,0,2);
    for (int k = 1; k <= 100; k++) begin
      logic exp_open;
      drive(0,0,0,0,ZERO);
      exp_open = TMO_EN ? (k < TMO) : 1'b1;
      check($sformatf("timeout_cycle%0d", k), exp_open, 0, 0, exp_open ? 2'd2 : 2'd0);
    end

    // Tailgating on the last allowed open cycle still wins over the timeout.
    drive(1,0,0,0,ZERO);
    drive(0,1,0,0,ZERO);
    drive(0,1,0,1,KEY);
    for (int k = 1; k < TMO; k++) begin
      drive(0,1,0,0,ZERO);
      check($sformatf("hold_open%0d", k), 1,0,0,2);
    end
    drive(0,1,1,0,ZERO);
    check("tailgate_at_timeout", 0,0,1,3);
    drive(0,0,0,1,KEY);
    check("unblock", 0,0,0,0);

    // Randomized traffic against the reference model.
    drive(1,0,0,0,ZERO);
    model_step(1,0,0,0,ZERO);
    check("rand_reset", 0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      logic r, a, i, v;
      logic [15:0] p;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 1) == 1);
      i = ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 1) == 1) ? KEY : 16'($urandom());
      drive(r, a, i, v, p);
      model_step(r, a, i, v, p);
      check($sformatf("rand%0d", n), m_open, m_alarm, m_blocked, model_estado());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
